jtvigil_scr2: RTL and testbench
===============================

# jtvigil_scr2

Background (scroll 2) layer renderer for the Vigilante core. It sits directly downstream of the main CPU block and consumes the `scr2pos`/`scr2col`/`flip` registers that block produces. It fetches one line ahead from the background graphics ROM into a double line buffer. It then emits 7-bit palette indices in sync with the video timing for the colour mixer.

## Interface
Parameters:
- `HOFFSET`, 0: signed pixel offset added to the read position, used for alignment against the other layers.

Ports:
- `clk`  in  1  system clock (48 MHz domain)
- `rst`  in  1  reset, synchronous, active-high
- `pxl_cen`  in  1  pixel clock enable
- `LHBL`  in  1  horizontal blank, active low
- `LVBL`  in  1  vertical blank, active low
- `h`  in  9  current render column
- `v`  in  9  current render line
- `flip`  in  1  screen flip
- `scr2pos`  in  11  background horizontal scroll
- `scr2col`  in  3  background colour bank
- `rom_cs`  out  1  ROM request
- `rom_addr`  out  16  ROM word address (32-bit words)
- `rom_data`  in  32  ROM word
- `rom_ok`  in  1  ROM data valid for current `rom_addr`
- `pxl`  out  7  `{colour bank, 4-bit pixel}`

## Operation
**Line buffers**
- Two 512×4-bit buffers.
- One is read for display while the other is filled for the next line.
- `bufsel` toggles on every LHBL falling edge (start of hblank).

**Line fetch**
- At each LHBL falling edge, sample the following into internal registers; mid-line CPU writes must not tear the line being fetched:
  - `scr = scr2pos`
  - `col = scr2col`
  - `vf = (v+1)[7:0] ^ {8{flip}}`
- Word address: `rom_addr = {vf, wcol}`.
  - `wcol` is 8 bits, initialised to `scr[10:3]` and incremented per word.
  - `wcol` wraps 255→0, giving a seamless 2048-pixel-wide layer.
- Each word holds 8 pixels, 4 bpp, leftmost pixel in bits [31:28].
- 33 words are fetched: 264 pixels, written to fill-buffer addresses 0..263.

**Fetch FSM**
- IDLE: waits for the LHBL falling edge, then loads the counters and goes to REQ.
- REQ: asserts `rom_cs`, holds `rom_addr`, waits for `rom_ok`, then latches the word and goes to WR.
- WR: writes one pixel per `clk` (8 cycles), shifting the word left by 4 each cycle. Then:
  - if `wcnt == 32`, goes to IDLE with `rom_cs` low;
  - otherwise increments `wcol`/`wcnt` and goes to REQ.
- A new LHBL falling edge while not in IDLE aborts the current fetch and restarts it for the new line. Unwritten addresses keep stale data.
- `rom_cs` drops for at least one cycle between words; the address changes only while `rom_cs` is low.

**Readout**
- Read address = `(flip ? 8'd255 - h[7:0] : h[7:0]) + scr[2:0] + HOFFSET`, taken from the display buffer, 9-bit.
- Colour bank: the `col` captured at the start of the previous fetch travels with its buffer, i.e. the bank is swapped together with the buffer.
- `pxl` is forced to 0 while `LVBL` or `LHBL` is low.
- The layer has no transparency.

## Timing
- Reset:
  - FSM goes to IDLE; `rom_cs = 0`, `rom_addr = 0`, `pxl = 0`, `bufsel = 0`.
  - Buffer contents are undefined.
- Reset mid-fetch: FSM returns to IDLE within one cycle; the fetch does not resume until the next LHBL falling edge.
- Fetch budget with zero-wait ROM is 33 × (1 REQ + 1 latch + 8 WR) = 330 clk. This is well under one line at 8 clk/pixel.
- `pxl` updates only on `pxl_cen`.
  - Latency from `h` to `pxl` is one `pxl_cen` period.
  - Buffer read data is registered on the `clk` before `pxl_cen`.
- `rom_ok` stalls of any length are tolerated; only line overrun aborts a fetch.

## Test plan
- Zero-wait ROM, word = `{v[7:0], wcol}` pattern, `scr2pos = 0`, `scr2col = 5`, `flip = 0` → on line v+1, pixel at `h = 8k+j` equals `{3'd5, nibble j of word(v, k)}`; exactly 33 `rom_cs` pulses per line.
- `scr2pos = 11'h7FB` → first word fetched is `wcol = 0xFF`, the second `wcol = 0x00`; displayed pixel 0 = nibble 3 of word `0xFF`.
- `flip = 1`, `v = 10` → fetch uses `vf = ~8'd11 = 8'hF4`; display of `h = 0` shows the pixel buffered at 255 + fine scroll.
- Write `scr2pos` and `scr2col` mid-line (h = 100) → current and next lines are unaffected; the change appears one line after the next LHBL falling edge.
- `rom_ok` held low for 2000 clk → fetch is aborted at the next LHBL falling edge and restarts with the new `vf`; no `rom_addr` change while `rom_cs` is high.
- Assert `rst` for 1 cycle mid-WR → `rom_cs = 0` and `pxl = 0` the next cycle; normal fetch resumes on the following hblank.

Source files
------------

// File: rtl/jtvigil_scr2_if.sv
// Background graphics ROM port: word request/response handshake.
interface jtvigil_scr2_if;
  logic        cs;
  logic [15:0] addr;
  logic [31:0] data;
  logic        ok;

  modport master (output cs, addr, input data, ok);
  modport slave  (input cs, addr, output data, ok);
endinterface

// File: rtl/jtvigil_scr2.sv
// Vigilante scroll-2 background: fetches the next line from ROM into a
// double 512x4 line buffer and plays the other buffer back as palette indices.
module jtvigil_scr2 #(
  parameter int HOFFSET = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pxl_cen,
  input  logic                  LHBL,
  input  logic                  LVBL,
  input  logic [8:0]            h,
  input  logic [8:0]            v,
  input  logic                  flip,
  input  logic [10:0]           scr2pos,
  input  logic [2:0]            scr2col,
  jtvigil_scr2_if.master        rom,
  output logic [6:0]            pxl
);

  localparam logic [8:0] HOFF = 9'(HOFFSET);

  typedef enum logic [1:0] {IDLE, REQ, WR} st_t;

  st_t         st;
  logic        lhbl_l, hb_edge, bufsel;
  logic        rom_cs;
  logic [15:0] rom_addr;
  logic [10:0] scr;
  logic [2:0]  col, col_disp, fine_disp;
  logic [7:0]  vf, wcol;
  logic [5:0]  wcnt;
  logic [2:0]  pcnt;
  logic [8:0]  waddr;
  logic [31:0] word;
  logic        wr_en;

  logic [3:0]  lbuf [0:1023];
  logic [3:0]  rd_data;
  logic [7:0]  hx;
  logic [8:0]  rd_addr;
  logic        unused;

  assign unused   = ^{h[8], v[8]};
  assign hb_edge  = lhbl_l & ~LHBL;
  assign rom.cs   = rom_cs;
  assign rom.addr = rom_addr;

  // Fetch FSM. A new hblank always wins: whatever was in flight is dropped
  // and the next line starts over with freshly sampled scroll registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      lhbl_l    <= 1'b0;
      bufsel    <= 1'b0;
      rom_cs    <= 1'b0;
      rom_addr  <= 16'd0;
      scr       <= 11'd0;
      col       <= 3'd0;
      col_disp  <= 3'd0;
      fine_disp <= 3'd0;
      vf        <= 8'd0;
      wcol      <= 8'd0;
      wcnt      <= 6'd0;
      pcnt      <= 3'd0;
      waddr     <= 9'd0;
      word      <= 32'd0;
    end else begin
      lhbl_l <= LHBL;
      if (hb_edge) begin
        bufsel    <= ~bufsel;
        // the finished buffer keeps the bank and fine scroll it was fetched with
        col_disp  <= col;
        fine_disp <= scr[2:0];
        scr       <= scr2pos;
        col       <= scr2col;
        vf        <= (v[7:0] + 8'd1) ^ {8{flip}};
        wcol      <= scr2pos[10:3];
        wcnt      <= 6'd0;
        waddr     <= 9'd0;
        pcnt      <= 3'd0;
        rom_cs    <= 1'b0;
        st        <= REQ;
      end else begin
        case (st)
          REQ: begin
            // address moves only in the cs-low cycle
            if (!rom_cs) begin
              rom_addr <= {vf, wcol};
              rom_cs   <= 1'b1;
            end else if (rom.ok) begin
              word   <= rom.data;
              rom_cs <= 1'b0;
              st     <= WR;
            end
          end
          WR: begin
            word  <= word << 4;
            waddr <= waddr + 9'd1;
            pcnt  <= pcnt + 3'd1;
            if (pcnt == 3'd7) begin
              if (wcnt == 6'd32) begin
                st <= IDLE;
              end else begin
                wcnt <= wcnt + 6'd1;
                wcol <= wcol + 8'd1;
                st   <= REQ;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign wr_en   = (st == WR) && !hb_edge;
  assign hx      = flip ? 8'd255 - h[7:0] : h[7:0];
  assign rd_addr = {1'b0, hx} + {6'd0, fine_disp} + HOFF;

  // bufsel selects the display half; the other half is being filled
  always_ff @(posedge clk) begin
    if (wr_en) lbuf[{~bufsel, waddr}] <= word[31:28];
    rd_data <= lbuf[{bufsel, rd_addr}];
  end

  always_ff @(posedge clk) begin
    if (rst)
      pxl <= 7'd0;
    else if (pxl_cen)
      pxl <= (LHBL && LVBL) ? {col_disp, rd_data} : 7'd0;
  end

endmodule

// File: tb/tb_jtvigil_scr2.sv
// Bench for jtvigil_scr2: drives line timing, serves a hashed ROM and compares
// fetch requests and displayed pixels against a line-level reference model.
module tb_jtvigil_scr2;
  localparam int HB = 16;

  logic        clk = 1'b0, rst = 1'b1;
  logic        pxl_cen;
  logic        LHBL = 1'b1, LVBL = 1'b1, flip = 1'b0;
  logic [8:0]  h = 9'd0, v = 9'd0;
  logic [10:0] scr2pos = 11'd0;
  logic [2:0]  scr2col = 3'd0;
  logic [6:0]  pxl;

  jtvigil_scr2_if rom_if();

  jtvigil_scr2 dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .h(h), .v(v), .flip(flip), .scr2pos(scr2pos), .scr2col(scr2col),
    .rom(rom_if), .pxl(pxl)
  );

  always #5 clk = ~clk;

  logic [2:0] cen_cnt = 3'd0;
  always @(posedge clk) cen_cnt <= cen_cnt + 3'd1;
  assign pxl_cen = (cen_cnt == 3'd7);

  function automatic logic [31:0] rom_word(input logic [15:0] a);
    return (32'(a) * 32'h9E3779B1) ^ {a, ~a};
  endfunction

  // ROM with optional random wait states and a hard stall
  int max_wait = 0;
  bit stall = 0;
  int ok_cnt = 0;
  always @(posedge clk)
    if (!rom_if.cs) ok_cnt <= (max_wait == 0) ? 0 : int'($urandom_range(0, max_wait));
    else if (ok_cnt != 0) ok_cnt <= ok_cnt - 1;
  assign rom_if.ok   = rom_if.cs && (ok_cnt == 0) && !stall;
  assign rom_if.data = rom_word(rom_if.addr);

  logic [15:0] req_q[$];
  logic        cs_q = 1'b0;
  logic [15:0] addr_q = 16'd0;
  int          addr_viol = 0;
  always @(negedge clk) begin
    if (rom_if.cs && !cs_q) req_q.push_back(rom_if.addr);
    if (rom_if.cs && cs_q && rom_if.addr !== addr_q) addr_viol <= addr_viol + 1;
    cs_q   <= rom_if.cs;
    addr_q <= rom_if.addr;
  end

  // reference model: parameters of the buffer being filled / displayed
  logic [10:0] f_scr = 0, d_scr = 0;
  logic [2:0]  f_col = 0, d_col = 0;
  logic [7:0]  f_vf = 0, d_vf = 0;
  bit          f_ok = 0, d_ok = 0;
  bit          next_flip = 0;
  int          req_base = 0;

  int checks = 0, errors = 0;
  int pix_bad, pix_cnt;
  logic [8:0] bad_h;
  logic [6:0] bad_got, bad_exp, px_h0;
  logic rst_cs, rst_pxl;
  bit rst_to;

  function automatic logic [3:0] exp_nib(input logic [10:0] s, input logic [7:0] vfv, input logic [8:0] a);
    logic [7:0]  wc;
    logic [31:0] w;
    wc = s[10:3] + {2'b0, a[8:3]};
    w  = rom_word({vfv, wc}) << (4 * a[2:0]);
    return w[31:28];
  endfunction

  function automatic int fetch_errs(input logic [10:0] s, input logic [7:0] vfv);
    int b = 0;
    if (req_q.size() - req_base != 33) return 1000;
    for (int k = 0; k < 33; k++)
      if (req_q[req_base + k] !== {vfv, 8'(int'(s[10:3]) + k)}) b++;
    return b;
  endfunction

  task automatic cen_edge();
    do @(negedge clk); while (!pxl_cen);
    @(posedge clk); #1;
  endtask

  task automatic do_line(input logic [8:0] vl, input bit lvbl, input bit rst_mid,
                         input bit mid_en, input logic [10:0] mid_scr, input logic [2:0] mid_col);
    logic [6:0] pend;
    bit pend_vld, pend_h0;
    logic [8:0] ra;
    int t;
    pix_bad = 0; pix_cnt = 0; pend = 0; pend_vld = 0; pend_h0 = 0;
    px_h0 = 7'h7f; rst_to = 0;
    for (int p = 0; p < HB + 256; p++) begin
      cen_edge();
      if (pend_vld) begin
        pix_cnt++;
        if (pxl !== pend) begin
          if (pix_bad == 0) begin bad_h = h; bad_got = pxl; bad_exp = pend; end
          pix_bad++;
        end
      end
      if (pend_h0) px_h0 = pxl;
      if (p == 0) begin
        LHBL = 0; v = vl; flip = next_flip;
        d_scr = f_scr; d_col = f_col; d_vf = f_vf; d_ok = f_ok;
        f_scr = scr2pos; f_col = scr2col; f_vf = (vl[7:0] + 8'd1) ^ {8{next_flip}}; f_ok = 1;
        req_base = req_q.size();
      end
      if (p == HB) LHBL = 1;
      LVBL = lvbl;
      h = (p < HB) ? 9'(256 + p) : 9'(p - HB);
      if (mid_en && p == HB + 100) begin scr2pos = mid_scr; scr2col = mid_col; end
      if (rst_mid && p == HB + 4) begin
        t = 0;
        while (rom_if.cs !== 1'b1 && t < 40) begin @(posedge clk); #1; t++; end
        if (t == 40) rst_to = 1;
        t = 0;
        while (rom_if.cs !== 1'b0 && t < 40) begin @(posedge clk); #1; t++; end
        if (t == 40) rst_to = 1;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst_cs = rom_if.cs; rst_pxl = |pxl;
        rst = 0;
        f_ok = 0; d_ok = 0;
      end
      pend_h0 = LHBL && (h == 9'd0);
      if (!LHBL || !LVBL) begin
        pend = 7'd0; pend_vld = 1;
      end else if (d_ok) begin
        ra = 9'((flip ? 255 - int'(h[7:0]) : int'(h[7:0])) + int'(d_scr[2:0]));
        pend = {d_col, exp_nib(d_scr, d_vf, ra)};
        pend_vld = 1;
      end else begin
        pend_vld = 0;
      end
    end
    LVBL = 1;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (rom_if.cs !== 1'b0) begin errors++; $display("FAIL reset_cs: got %b expected 0", rom_if.cs); end
    checks++; if (rom_if.addr !== 16'd0) begin errors++; $display("FAIL reset_addr: got %h expected 0000", rom_if.addr); end
    checks++; if (pxl !== 7'd0) begin errors++; $display("FAIL reset_pxl: got %h expected 00", pxl); end
    rst = 0;
  endtask

  task automatic test_basic();
    int e;
    scr2pos = 0; scr2col = 5; next_flip = 0; max_wait = 0;
    for (int i = 0; i < 3; i++) begin
      do_line(9'(20 + i), 1, 0, 0, 0, 0);
      checks++; if (req_q.size() - req_base !== 33) begin errors++; $display("FAIL basic_pulses line %0d: got %0d expected 33", i, req_q.size() - req_base); end
      e = fetch_errs(f_scr, f_vf);
      checks++; if (e !== 0) begin errors++; $display("FAIL basic_addr line %0d: %0d bad addresses expected 0", i, e); end
      if (i > 0) begin
        checks++; if (pix_bad !== 0 || pix_cnt < 256) begin errors++; $display("FAIL basic_pix line %0d: %0d bad of %0d, h=%0d got %h expected %h", i, pix_bad, pix_cnt, bad_h, bad_got, bad_exp); end
      end
    end
  endtask

  task automatic test_random();
    int e;
    max_wait = 3;
    for (int i = 0; i < 4; i++) begin
      scr2pos = 11'($urandom_range(0, 2047));
      scr2col = 3'($urandom_range(0, 7));
      next_flip = bit'($urandom_range(0, 1));
      do_line(9'($urandom_range(0, 255)), 1, 0, 0, 0, 0);
      e = fetch_errs(f_scr, f_vf);
      checks++; if (e !== 0) begin errors++; $display("FAIL rand_fetch line %0d: %0d bad expected 0", i, e); end
      checks++; if (pix_bad !== 0) begin errors++; $display("FAIL rand_pix line %0d: %0d bad, h=%0d got %h expected %h", i, pix_bad, bad_h, bad_got, bad_exp); end
    end
    max_wait = 0; next_flip = 0;
  endtask

  task automatic test_wrap();
    logic [31:0] w;
    scr2pos = 11'h7FB; scr2col = 2;
    do_line(9'd30, 1, 0, 0, 0, 0);
    checks++; if (req_q[req_base][7:0] !== 8'hFF) begin errors++; $display("FAIL wrap_first: got %h expected ff", req_q[req_base][7:0]); end
    checks++; if (req_q[req_base + 1][7:0] !== 8'h00) begin errors++; $display("FAIL wrap_second: got %h expected 00", req_q[req_base + 1][7:0]); end
    do_line(9'd31, 1, 0, 0, 0, 0);
    w = rom_word({8'd31, 8'hFF});
    checks++; if (px_h0 !== {3'd2, w[19:16]}) begin errors++; $display("FAIL wrap_px0: got %h expected %h", px_h0, {3'd2, w[19:16]}); end
    checks++; if (pix_bad !== 0) begin errors++; $display("FAIL wrap_pix: %0d bad, h=%0d got %h expected %h", pix_bad, bad_h, bad_got, bad_exp); end
  endtask

  task automatic test_flip();
    logic [31:0] w;
    scr2pos = 11'h005; scr2col = 4; next_flip = 1;
    do_line(9'd10, 1, 0, 0, 0, 0);
    checks++; if (req_q[req_base][15:8] !== 8'hF4) begin errors++; $display("FAIL flip_vf: got %h expected f4", req_q[req_base][15:8]); end
    do_line(9'd11, 1, 0, 0, 0, 0);
    w = rom_word({8'hF4, 8'h20});
    checks++; if (px_h0 !== {3'd4, w[15:12]}) begin errors++; $display("FAIL flip_px0: got %h expected %h", px_h0, {3'd4, w[15:12]}); end
    checks++; if (pix_bad !== 0) begin errors++; $display("FAIL flip_pix: %0d bad, h=%0d got %h expected %h", pix_bad, bad_h, bad_got, bad_exp); end
    next_flip = 0;
    do_line(9'd12, 1, 0, 0, 0, 0);
    checks++; if (pix_bad !== 0) begin errors++; $display("FAIL unflip_pix: %0d bad, h=%0d got %h expected %h", pix_bad, bad_h, bad_got, bad_exp); end
  endtask

  task automatic test_midline();
    int e;
    scr2pos = 11'h123; scr2col = 3;
    do_line(9'd40, 1, 0, 0, 0, 0);
    do_line(9'd41, 1, 0, 1, 11'h456, 3'd6);
    e = fetch_errs(11'h123, 8'd42);
    checks++; if (e !== 0) begin errors++; $display("FAIL mid_fetch_torn: %0d bad expected 0", e); end
    checks++; if (pix_bad !== 0) begin errors++; $display("FAIL mid_cur_pix: %0d bad, h=%0d got %h expected %h", pix_bad, bad_h, bad_got, bad_exp); end
    do_line(9'd42, 1, 0, 0, 0, 0);
    checks++; if (px_h0[6:4] !== 3'd3) begin errors++; $display("FAIL mid_next_bank: got %0d expected 3", px_h0[6:4]); end
    checks++; if (pix_bad !== 0) begin errors++; $display("FAIL mid_next_pix: %0d bad, h=%0d got %h expected %h", pix_bad, bad_h, bad_got, bad_exp); end
    do_line(9'd43, 1, 0, 0, 0, 0);
    checks++; if (px_h0[6:4] !== 3'd6) begin errors++; $display("FAIL mid_after_bank: got %0d expected 6", px_h0[6:4]); end
    checks++; if (pix_bad !== 0) begin errors++; $display("FAIL mid_after_pix: %0d bad, h=%0d got %h expected %h", pix_bad, bad_h, bad_got, bad_exp); end
  endtask

  task automatic test_vblank();
    do_line(9'd50, 0, 0, 0, 0, 0);
    checks++; if (px_h0 !== 7'd0) begin errors++; $display("FAIL vblank_px0: got %h expected 00", px_h0); end
    checks++; if (pix_bad !== 0) begin errors++; $display("FAIL vblank_pix: %0d bad, h=%0d got %h expected 00", pix_bad, bad_h, bad_got); end
  endtask

  task automatic test_stall();
    int e;
    scr2pos = 11'h2A9; scr2col = 1;
    stall = 1;
    do_line(9'd60, 1, 0, 0, 0, 0);
    checks++; if (req_q.size() - req_base !== 1) begin errors++; $display("FAIL stall_pulses: got %0d expected 1", req_q.size() - req_base); end
    checks++; if (rom_if.cs !== 1'b1) begin errors++; $display("FAIL stall_cs_held: got %b expected 1", rom_if.cs); end
    f_ok = 0;
    stall = 0;
    do_line(9'd61, 1, 0, 0, 0, 0);
    e = fetch_errs(f_scr, 8'd62);
    checks++; if (e !== 0) begin errors++; $display("FAIL stall_restart: %0d bad expected 0", e); end
    do_line(9'd62, 1, 0, 0, 0, 0);
    checks++; if (pix_bad !== 0 || pix_cnt < 256) begin errors++; $display("FAIL stall_recover_pix: %0d bad of %0d, h=%0d got %h expected %h", pix_bad, pix_cnt, bad_h, bad_got, bad_exp); end
    checks++; if (addr_viol !== 0) begin errors++; $display("FAIL addr_stable: got %0d changes expected 0", addr_viol); end
  endtask

  task automatic test_rst_mid();
    int e;
    scr2pos = 11'h0F0; scr2col = 7; max_wait = 0;
    do_line(9'd70, 1, 1, 0, 0, 0);
    checks++; if (rst_to !== 1'b0) begin errors++; $display("FAIL rst_wait: got timeout expected fetch activity"); end
    checks++; if (rst_cs !== 1'b0) begin errors++; $display("FAIL rst_cs: got %b expected 0", rst_cs); end
    checks++; if (rst_pxl !== 1'b0) begin errors++; $display("FAIL rst_pxl: got nonzero expected 0"); end
    do_line(9'd71, 1, 0, 0, 0, 0);
    e = fetch_errs(f_scr, f_vf);
    checks++; if (e !== 0) begin errors++; $display("FAIL rst_resume_fetch: %0d bad expected 0", e); end
    do_line(9'd72, 1, 0, 0, 0, 0);
    checks++; if (pix_bad !== 0 || pix_cnt < 256) begin errors++; $display("FAIL rst_resume_pix: %0d bad of %0d, h=%0d got %h expected %h", pix_bad, pix_cnt, bad_h, bad_got, bad_exp); end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_wrap();
    test_flip();
    test_midline();
    test_vblank();
    test_stall();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
